// File: rtl/led_matrix_pkg.sv
// Shared widths, limits and the sequencer state type for the led_matrix playback path.
package led_matrix_pkg;
    localparam int FRAME_W     = 32;
    localparam int INTENSITY_W = 4;
    localparam logic [INTENSITY_W-1:0] INTENSITY_MAX = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        FADE_IN,
        SHOW,
        FADE_OUT
    } seq_state_t;
endpackage

// File: rtl/led_matrix_sequencer_frame_store.sv
// Frame buffer: one write port, combinational read of pattern and hold count.
module frame_store
    import led_matrix_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 8,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [PTR_W-1:0]   wr_addr,
    input  logic [FRAME_W-1:0] wr_data,
    input  logic [HOLD_W-1:0]  wr_hold,
    input  logic [PTR_W-1:0]   rd_addr,
    output logic [FRAME_W-1:0] rd_data,
    output logic [HOLD_W-1:0]  rd_hold
);
    logic [FRAME_W+HOLD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_data, wr_hold};
        end
    end

    assign {rd_data, rd_hold} = mem[rd_addr];
endmodule

// File: rtl/led_matrix_sequencer.sv
// Frame-playback controller: steps buffered frames onto led_matrix at refresh boundaries,
// optionally fading intensity out and back in around every frame swap.
module led_matrix_sequencer
    import led_matrix_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 8,
    parameter int FADE   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [FRAME_W-1:0]       wr_data,
    input  logic [HOLD_W-1:0]        wr_hold,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    input  logic                     frame_tick,
    output logic [FRAME_W-1:0]       data,
    output logic [INTENSITY_W-1:0]   intensity,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    seq_state_t             state_q, state_d;
    logic [FRAME_W-1:0]     data_q, data_d;
    logic [INTENSITY_W-1:0] intensity_q, intensity_d;
    logic                   done_q, done_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;

    logic                   clear_idle, wr_accept, advance;
    logic [CNT_W-1:0]       count_next, count_m1;
    logic [PTR_W-1:0]       last_ptr, adv_ptr, rd_addr;
    logic [FRAME_W-1:0]     rd_frame, start_frame;
    logic [HOLD_W-1:0]      rd_hold, start_hold;

    function automatic logic [HOLD_W-1:0] hold_min1(input logic [HOLD_W-1:0] h);
        return (h == '0) ? HOLD_W'(1) : h;
    endfunction

    assign wr_ready   = (state_q == IDLE) && (count_q < CNT_W'(DEPTH));
    assign clear_idle = clear && (state_q == IDLE);
    assign wr_accept  = wr_valid && wr_ready && !clear_idle;
    assign count_next = clear_idle ? '0 : count_q + CNT_W'(wr_accept);

    assign count_m1 = count_q - CNT_W'(1);
    assign last_ptr = count_m1[PTR_W-1:0];
    assign adv_ptr  = (rd_ptr_q == last_ptr) ? '0 : rd_ptr_q + PTR_W'(1);

    // FADE_IN needs the hold of the frame on screen; every other state looks ahead to the next slot.
    always_comb begin
        rd_addr = adv_ptr;
        if (state_q == IDLE) begin
            rd_addr = '0;
        end else if (state_q == FADE_IN) begin
            rd_addr = rd_ptr_q;
        end
    end

    frame_store #(
        .DEPTH  (DEPTH),
        .HOLD_W (HOLD_W),
        .PTR_W  (PTR_W)
    ) u_store (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (count_q[PTR_W-1:0]),
        .wr_data (wr_data),
        .wr_hold (wr_hold),
        .rd_addr (rd_addr),
        .rd_data (rd_frame),
        .rd_hold (rd_hold)
    );

    // A start that arrives with the very first write must play that write, not the empty slot.
    assign start_frame = (count_q == '0) ? wr_data : rd_frame;
    assign start_hold  = (count_q == '0) ? wr_hold : rd_hold;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        intensity_d = intensity_q;
        done_d      = 1'b0;
        count_d     = count_next;
        rd_ptr_d    = rd_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        advance     = 1'b0;

        if (stop) begin
            state_d     = IDLE;
            intensity_d = '0;
            rd_ptr_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !clear_idle && (count_next != '0)) begin
                        data_d   = start_frame;
                        rd_ptr_d = '0;
                        if (FADE != 0) begin
                            intensity_d = '0;
                            state_d     = FADE_IN;
                        end else begin
                            intensity_d = INTENSITY_MAX;
                            hold_cnt_d  = hold_min1(start_hold);
                            state_d     = SHOW;
                        end
                    end
                end
                FADE_IN: begin
                    if (frame_tick) begin
                        if (intensity_q >= INTENSITY_MAX - 4'd1) begin
                            intensity_d = INTENSITY_MAX;
                            hold_cnt_d  = hold_min1(rd_hold);
                            state_d     = SHOW;
                        end else begin
                            intensity_d = intensity_q + 4'd1;
                        end
                    end
                end
                SHOW: begin
                    if (frame_tick) begin
                        hold_cnt_d = (hold_cnt_q == '0) ? '0 : hold_cnt_q - HOLD_W'(1);
                        if (hold_cnt_q <= HOLD_W'(1)) begin
                            if (FADE != 0) begin
                                state_d = FADE_OUT;
                            end else begin
                                advance = 1'b1;
                            end
                        end
                    end
                end
                FADE_OUT: begin
                    if (frame_tick) begin
                        if (intensity_q == '0) begin
                            advance = 1'b1;
                        end else begin
                            intensity_d = intensity_q - 4'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (advance) begin
                if ((rd_ptr_q != last_ptr) || loop) begin
                    rd_ptr_d = adv_ptr;
                    data_d   = rd_frame;
                    if (FADE != 0) begin
                        state_d = FADE_IN;
                    end else begin
                        hold_cnt_d = hold_min1(rd_hold);
                        state_d    = SHOW;
                    end
                end else begin
                    done_d   = 1'b1;
                    rd_ptr_d = '0;
                    state_d  = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            intensity_q <= '0;
            done_q      <= 1'b0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            intensity_q <= intensity_d;
            done_q      <= done_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign data      = data_q;
    assign intensity = intensity_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign count     = count_q;
endmodule
